// File: rtl/mode4_exp_accum_pkg.sv
// Shared types, constants and the FP16 adder used by the mode-4 accumulate stage.
package mode4_exp_accum_pkg;

    localparam int unsigned FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // FP16 add, round-to-nearest-even, subnormals kept, overflow to signed inf,
    // any NaN or inf-inf gives the quiet NaN.
    // The smaller operand is aligned into 11+3 bits (guard, round, sticky) so a
    // single rounding step after normalisation is exact.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic        sa, sb, s_big, s_res;
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [4:0]  ea, eb, ex_a, ex_b, ex_big, ex_small, diff;
        logic [10:0] sig_a, sig_b, sig_big, sig_small;
        logic [41:0] wide;
        logic [13:0] big_ext, small_ext, norm;
        logic [14:0] sum;
        logic [6:0]  ex;
        logic [11:0] man_r;
        logic        rnd_up;
        logic [15:0] res;

        sa    = a[15];
        sb    = b[15];
        ea    = a[14:10];
        eb    = b[14:10];
        a_nan = (ea == 5'h1F) && (a[9:0] != '0);
        b_nan = (eb == 5'h1F) && (b[9:0] != '0);
        a_inf = (ea == 5'h1F) && (a[9:0] == '0);
        b_inf = (eb == 5'h1F) && (b[9:0] == '0);
        sig_a = {(ea != '0), a[9:0]};
        sig_b = {(eb != '0), b[9:0]};
        ex_a  = (ea == '0) ? 5'd1 : ea;
        ex_b  = (eb == '0) ? 5'd1 : eb;

        if (a[14:0] >= b[14:0]) begin
            s_big     = sa;
            sig_big   = sig_a;
            ex_big    = ex_a;
            sig_small = sig_b;
            ex_small  = ex_b;
        end else begin
            s_big     = sb;
            sig_big   = sig_b;
            ex_big    = ex_b;
            sig_small = sig_a;
            ex_small  = ex_a;
        end

        diff      = ex_big - ex_small;
        big_ext   = {sig_big, 3'b000};
        wide      = {sig_small, 31'd0} >> diff;
        small_ext = {wide[41:29], wide[28] | (|wide[27:0])};

        if (sa == sb) begin
            sum = {1'b0, big_ext} + {1'b0, small_ext};
        end else begin
            sum = {1'b0, big_ext} - {1'b0, small_ext};
        end

        ex = {2'b00, ex_big};
        if (sum[14]) begin
            norm = {sum[14:2], sum[1] | sum[0]};
            ex   = ex + 7'd1;
        end else begin
            norm = sum[13:0];
        end
        for (int unsigned i = 0; i < 13; i++) begin
            if (!norm[13] && (ex > 7'd1)) begin
                norm = norm << 1;
                ex   = ex - 7'd1;
            end
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r  = {1'b0, norm[13:3]} + {11'd0, rnd_up};
        if (man_r[11]) begin
            man_r = man_r >> 1;
            ex    = ex + 7'd1;
        end

        s_res = (sum == '0) ? (sa & sb) : s_big;
        if (ex >= 7'd31) begin
            res = {s_res, 5'h1F, 10'd0};
        end else begin
            res = {s_res, (man_r[10] ? ex[4:0] : 5'd0), man_r[9:0]};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res = FP16_QNAN;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end
        return res;
    endfunction

endpackage

// File: rtl/mode4_add_tree.sv
// Combinational halves of the 4->1 reduction; the stage registers live in the top.
module mode4_add_tree
    import mode4_exp_accum_pkg::*;
#(
    parameter int unsigned DATAWIDTH = FP16_W
) (
    input  logic [DATAWIDTH-1:0] inp0,
    input  logic [DATAWIDTH-1:0] inp1,
    input  logic [DATAWIDTH-1:0] inp2,
    input  logic [DATAWIDTH-1:0] inp3,
    input  logic [DATAWIDTH-1:0] p0,
    input  logic [DATAWIDTH-1:0] p1,
    output logic [DATAWIDTH-1:0] pair0_sum,
    output logic [DATAWIDTH-1:0] pair1_sum,
    output logic [DATAWIDTH-1:0] tree_sum
);

    // Lane pairs feed S1, registered pair sums feed the final S2 add.
    always_comb begin
        pair0_sum = fp16_add(inp0, inp1);
        pair1_sum = fp16_add(inp2, inp3);
        tree_sum  = fp16_add(p0, p1);
    end

endmodule

// File: rtl/mode4_exp_accum.sv
// Softmax mode-4: reduce 4 exp() lanes per beat and accumulate a job of beats.
module mode4_exp_accum
    import mode4_exp_accum_pkg::*;
#(
    parameter int unsigned DATAWIDTH = FP16_W,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_groups,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] inp0,
    input  logic [DATAWIDTH-1:0] inp1,
    input  logic [DATAWIDTH-1:0] inp2,
    input  logic [DATAWIDTH-1:0] inp3,
    output logic                 busy,
    output logic [DATAWIDTH-1:0] sum_out,
    output logic                 sum_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     recv_q, recv_d;
    logic                 busy_q, busy_d;
    logic [DATAWIDTH-1:0] sum_out_q, sum_out_d;
    logic                 sum_valid_q, sum_valid_d;
    logic                 acc_clr;

    logic [DATAWIDTH-1:0] p0_q, p0_d, p1_q, p1_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [DATAWIDTH-1:0] t_q, t_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;

    logic [DATAWIDTH-1:0] pair0_sum, pair1_sum, tree_sum, acc_sum;
    logic                 transfer;

    mode4_add_tree #(
        .DATAWIDTH(DATAWIDTH)
    ) u_tree (
        .inp0      (inp0),
        .inp1      (inp1),
        .inp2      (inp2),
        .inp3      (inp3),
        .p0        (p0_q),
        .p1        (p1_q),
        .pair0_sum (pair0_sum),
        .pair1_sum (pair1_sum),
        .tree_sum  (tree_sum)
    );

    assign transfer  = in_valid & in_ready;
    assign busy      = busy_q;
    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;

    // Job control: count accepted beats, wait for the pipe to empty, publish the sum.
    // The result is captured on the DRAIN->DONE transition so that sum_out and the
    // sum_valid pulse are both registered and appear together in the DONE cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        recv_d      = recv_q;
        busy_d      = busy_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = 1'b0;
        acc_clr     = 1'b0;
        in_ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_groups != '0) begin
                        count_d = num_groups;
                        recv_d  = '0;
                        busy_d  = 1'b1;
                        acc_clr = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        sum_out_d   = FP16_ZERO;
                        sum_valid_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    recv_d = recv_q + CNT_ONE;
                    if (recv_q == count_q - CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    sum_out_d   = acc_q;
                    sum_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running reduction pipe; only the valid bits qualify the data.
    always_comb begin
        p0_d     = pair0_sum;
        p1_d     = pair1_sum;
        s1_vld_d = transfer;
        t_d      = tree_sum;
        s2_vld_d = s1_vld_q;
        acc_sum  = fp16_add(acc_q, t_q);
        acc_d    = acc_q;
        if (acc_clr) begin
            acc_d = FP16_ZERO;
        end else if (s2_vld_q) begin
            acc_d = acc_sum;
        end
    end

    // State registers for control and datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            recv_q      <= '0;
            busy_q      <= 1'b0;
            sum_out_q   <= FP16_ZERO;
            sum_valid_q <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            s1_vld_q    <= 1'b0;
            t_q         <= '0;
            s2_vld_q    <= 1'b0;
            acc_q       <= FP16_ZERO;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            recv_q      <= recv_d;
            busy_q      <= busy_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            s1_vld_q    <= s1_vld_d;
            t_q         <= t_d;
            s2_vld_q    <= s2_vld_d;
            acc_q       <= acc_d;
        end
    end

endmodule
